// File: rtl/qe_bus_pkg.sv
// Shared types and default parameters for the QL expansion-bus to W5300 sequencer.
// Holds the FSM state encoding, decode/timing defaults and small constant helpers.
package qe_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_STROBE = 3'd2,
      ST_ACK    = 3'd3,
      ST_HOLD   = 3'd4,
      ST_RSTACK = 3'd5
   } state_e;

   localparam int          ADDR_W_DEF      = 10;
   localparam int          NUM_CH_DEF      = 2;
   localparam int          DEC_W_DEF       = 2;
   localparam logic [1:0]  DEC_BASE_DEF    = 2'b11;
   localparam int          CH_LSB_DEF      = 2;
   localparam logic [9:0]  RST_ADDR_DEF    = 10'h30c;
   localparam int          SETUP_CYC_DEF   = 1;
   localparam int          STROBE_CYC_DEF  = 3;
   localparam int          HOLD_CYC_DEF    = 1;
   localparam int          RESET_CYC_DEF   = 20;
   localparam int          TIMEOUT_CYC_DEF = 255;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/qe_sync2.sv
// Two-flop synchroniser for the asynchronous 68008 bus strobes.
// Both stages reset to RST_VAL so an idle (high) strobe is seen during reset.
module qe_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_d, meta_q;
   logic sync_d, sync_q;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/qe_wiz_bus_sequencer.sv
// QL expansion-bus sequencer for W5300 controllers: decode, chip-select/strobe timing,
// dtackl generation and a timed wizrstl pulse. Optional ACK timeout: QE_BUS_TIMEOUT_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for a decoded bus cycle (as_s, ds_s low, re-armed)
// ST_SETUP  | chip-select asserted, waiting SETUP_CYC before the strobe
// ST_STROBE | strobe asserted, waiting STROBE_CYC before dtackl
// ST_ACK    | dtackl low, strobe and cs held until ds_s rises
// ST_HOLD   | strobe released, cs held HOLD_CYC cycles
// ST_RSTACK | reset-register write acknowledged, wizrstl pulse restarted
module qe_wiz_bus_sequencer
   import qe_bus_pkg::*;
#(
   parameter int                ADDR_W      = ADDR_W_DEF,
   parameter int                NUM_CH      = NUM_CH_DEF,
   parameter int                DEC_W       = DEC_W_DEF,
   parameter logic [DEC_W-1:0]  DEC_BASE    = DEC_BASE_DEF,
   parameter int                CH_LSB      = CH_LSB_DEF,
   parameter logic [ADDR_W-1:0] RST_ADDR    = RST_ADDR_DEF,
   parameter int                SETUP_CYC   = SETUP_CYC_DEF,
   parameter int                STROBE_CYC  = STROBE_CYC_DEF,
   parameter int                HOLD_CYC    = HOLD_CYC_DEF,
   parameter int                RESET_CYC   = RESET_CYC_DEF,
   parameter int                TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] address,
   input  logic              asl,
   input  logic              dsl,
   input  logic              rdwl,
   output logic              dtackl,
   output logic              dsmcl,
   output logic              dbenl,
   output logic              dbdir,
   output logic [NUM_CH-1:0] wizcsl,
   output logic              wizrdl,
   output logic              wizwrl,
   output logic              wizrstl,
   output logic              busy,
   output logic              timeout_flag
);

   // A single channel still gets a 1-bit index so the field never collapses to zero width.
   localparam int CH_W    = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH);
   localparam int MAX_CYC = max2(max2(SETUP_CYC, STROBE_CYC), max2(HOLD_CYC, TIMEOUT_CYC));
   localparam int CNT_W   = clog2(MAX_CYC) + 1;
   localparam int RCNT_W  = clog2(RESET_CYC) + 1;

   localparam logic [CNT_W-1:0]  SETUP_LD  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0]  STROBE_LD = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0]  HOLD_LD   = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0]  TMO_LD    = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [RCNT_W-1:0] RESET_LD  = RCNT_W'(RESET_CYC - 1);

   logic as_s, ds_s, rw_s;

   qe_sync2 #(.RST_VAL(1'b1)) u_sync_as (.clk(clk), .rst(rst), .d(asl),  .q(as_s));
   qe_sync2 #(.RST_VAL(1'b1)) u_sync_ds (.clk(clk), .rst(rst), .d(dsl),  .q(ds_s));
   qe_sync2 #(.RST_VAL(1'b1)) u_sync_rw (.clk(clk), .rst(rst), .d(rdwl), .q(rw_s));

   logic [(1<<CH_W)-1:0] ch_valid;
   logic [CH_W-1:0]      ch_addr;
   logic                 dec_hit;
   logic                 hit;

   for (genvar g = 0; g < (1 << CH_W); g++) begin : g_ch_valid
      assign ch_valid[g] = (g < NUM_CH);
   end

   assign dec_hit = (address[ADDR_W-1 -: DEC_W] == DEC_BASE);
   assign ch_addr = address[CH_LSB +: CH_W];
   assign hit     = dec_hit & ch_valid[ch_addr];
   assign dsmcl   = ~(~asl & hit);

   state_e             state_d, state_q;
   logic [CNT_W-1:0]   cnt_d, cnt_q;
   logic [RCNT_W-1:0]  rcnt_d, rcnt_q;
   logic [CH_W-1:0]    ch_d, ch_q;
   logic               dir_d, dir_q;
   logic               arm_d, arm_q;
   logic               wizrstl_d, wizrstl_q;
   logic [NUM_CH-1:0]  wizcsl_d, wizcsl_q;
   logic               wizrdl_d, wizrdl_q;
   logic               wizwrl_d, wizwrl_q;
   logic               dtackl_d, dtackl_q;
   logic               dbenl_d, dbenl_q;
   logic               dbdir_d, dbdir_q;
   logic               busy_d, busy_q;
`ifdef QE_BUS_TIMEOUT_EN
   logic               tmo_evt;
   logic               flag_d, flag_q;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
      rcnt_d    = (rcnt_q != '0) ? rcnt_q - RCNT_W'(1) : rcnt_q;
      wizrstl_d = (rcnt_q == '0);
      ch_d      = ch_q;
      dir_d     = dir_q;
      arm_d     = arm_q | as_s;
`ifdef QE_BUS_TIMEOUT_EN
      tmo_evt   = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!as_s && !ds_s && hit && arm_q) begin
               arm_d = 1'b0;
               if (!rw_s && (address == RST_ADDR)) begin
                  state_d   = ST_RSTACK;
                  cnt_d     = TMO_LD;
                  rcnt_d    = RESET_LD;
                  wizrstl_d = 1'b0;
               end else begin
                  state_d = ST_SETUP;
                  cnt_d   = SETUP_LD;
                  ch_d    = ch_addr;
                  dir_d   = rw_s;
               end
            end
         end
         ST_SETUP: begin
            if (as_s) begin
               state_d = ST_HOLD;
               cnt_d   = HOLD_LD;
            end else if (cnt_q == '0) begin
               state_d = ST_STROBE;
               cnt_d   = STROBE_LD;
            end
         end
         ST_STROBE: begin
            if (as_s) begin
               state_d = ST_HOLD;
               cnt_d   = HOLD_LD;
            end else if (cnt_q == '0) begin
               state_d = ST_ACK;
               cnt_d   = TMO_LD;
            end
         end
         ST_ACK: begin
            if (ds_s) begin
               state_d = ST_HOLD;
               cnt_d   = HOLD_LD;
            end
`ifdef QE_BUS_TIMEOUT_EN
            else if (cnt_q == '0) begin
               state_d = ST_HOLD;
               cnt_d   = HOLD_LD;
               tmo_evt = 1'b1;
            end
`endif
         end
         ST_HOLD: begin
            if (cnt_q == '0) state_d = ST_IDLE;
         end
         ST_RSTACK: begin
            if (ds_s) begin
               state_d = ST_IDLE;
            end
`ifdef QE_BUS_TIMEOUT_EN
            else if (cnt_q == '0) begin
               state_d = ST_IDLE;
               tmo_evt = 1'b1;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
`ifdef QE_BUS_TIMEOUT_EN
      flag_d = flag_q | tmo_evt;
`endif
   end

   // Outputs decode the next state so every bus-side signal leaves a flop aligned with the state change.
   always_comb begin
      wizcsl_d = '1;
      wizrdl_d = 1'b1;
      wizwrl_d = 1'b1;
      dtackl_d = 1'b1;
      dbenl_d  = 1'b1;
      dbdir_d  = 1'b0;
      busy_d   = (state_d != ST_IDLE);
      if (state_d inside {ST_SETUP, ST_STROBE, ST_ACK, ST_HOLD}) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (ch_d == CH_W'(i)) wizcsl_d[i] = 1'b0;
         end
         dbenl_d = 1'b0;
         dbdir_d = dir_d;
      end
      if (state_d inside {ST_STROBE, ST_ACK}) begin
         wizrdl_d = ~dir_d;
         wizwrl_d = dir_d;
      end
      if (state_d inside {ST_ACK, ST_RSTACK}) dtackl_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         rcnt_q    <= RESET_LD;
         ch_q      <= '0;
         dir_q     <= 1'b0;
         arm_q     <= 1'b1;
         wizrstl_q <= 1'b0;
         wizcsl_q  <= '1;
         wizrdl_q  <= 1'b1;
         wizwrl_q  <= 1'b1;
         dtackl_q  <= 1'b1;
         dbenl_q   <= 1'b1;
         dbdir_q   <= 1'b0;
         busy_q    <= 1'b0;
`ifdef QE_BUS_TIMEOUT_EN
         flag_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rcnt_q    <= rcnt_d;
         ch_q      <= ch_d;
         dir_q     <= dir_d;
         arm_q     <= arm_d;
         wizrstl_q <= wizrstl_d;
         wizcsl_q  <= wizcsl_d;
         wizrdl_q  <= wizrdl_d;
         wizwrl_q  <= wizwrl_d;
         dtackl_q  <= dtackl_d;
         dbenl_q   <= dbenl_d;
         dbdir_q   <= dbdir_d;
         busy_q    <= busy_d;
`ifdef QE_BUS_TIMEOUT_EN
         flag_q    <= flag_d;
`endif
      end
   end

   assign dtackl  = dtackl_q;
   assign dbenl   = dbenl_q;
   assign dbdir   = dbdir_q;
   assign wizcsl  = wizcsl_q;
   assign wizrdl  = wizrdl_q;
   assign wizwrl  = wizwrl_q;
   assign wizrstl = wizrstl_q;
   assign busy    = busy_q;
`ifdef QE_BUS_TIMEOUT_EN
   assign timeout_flag = flag_q;
`else
   assign timeout_flag = 1'b0;
`endif

endmodule

// File: doc/qe_wiz_bus_sequencer.md
Name: qe_wiz_bus_sequencer

Overview:
- Next-generation QL expansion-bus interface to one or more W5300 Ethernet controllers.
- Decodes 68008 bus cycles (asl/dsl/rdwl) and suppresses motherboard memory.
- Sequences per-channel chip-select and read/write strobes with parametrised setup/strobe/hold timing, then generates dtackl.
- Adds multi-channel select, programmable wait timing and a software-triggered timed W5300 reset pulse.

Parameters:
ADDR_W, 10, address bus width
NUM_CH, 2, number of W5300 chip selects (1..4)
DEC_W, 2, number of top address bits compared for a hit
DEC_BASE, 2'b11, value of address[ADDR_W-1 -: DEC_W] that selects the block
CH_LSB, 2, lowest address bit of the channel index field (clog2(NUM_CH) bits wide)
RST_ADDR, 10'h30c, write to this address triggers the W5300 reset pulse
SETUP_CYC, 1, clk cycles from chip-select to strobe (>=1)
STROBE_CYC, 3, minimum strobe width before dtackl (>=1)
HOLD_CYC, 1, clk cycles chip-select is held after strobe release (>=1)
RESET_CYC, 20, wizrstl low width in clk cycles
TIMEOUT_CYC, 255, ACK wait limit (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
address  in  ADDR_W  QL address bus
asl  in  1  address strobe, active low, asynchronous to clk
dsl  in  1  data strobe, active low, asynchronous to clk
rdwl  in  1  1 = read, 0 = write
dtackl  out  1  data acknowledge to CPU, active low
dsmcl  out  1  motherboard memory disable, active low
dbenl  out  1  data buffer enable, active low
dbdir  out  1  buffer direction: 1 = card to QL (read)
wizcsl  out  NUM_CH  per-channel W5300 chip-select, active low
wizrdl  out  1  W5300 read strobe, active low
wizwrl  out  1  W5300 write strobe, active low
wizrstl  out  1  W5300 reset, active low
busy  out  1  FSM not in IDLE
timeout_flag  out  1  sticky bus-timeout indicator

Behaviour:
- Reset (rst high, async):
  - dtackl=1, dbenl=1, dbdir=0, wizcsl=all 1, wizrdl=1, wizwrl=1, busy=0, timeout_flag=0.
  - wizrstl=0. After rst falls it stays low for RESET_CYC further cycles, then goes high.
  - Reset asserted mid-cycle returns all outputs to these values immediately.
- Synchronisation: asl, dsl and rdwl each pass through a 2-flop synchroniser (as_s, ds_s, rw_s). address is sampled only when as_s is low.
- Decode: hit = (address[ADDR_W-1 -: DEC_W] == DEC_BASE). ch = address[CH_LSB +: clog2(NUM_CH)]. A ch value >= NUM_CH is a miss.
- dsmcl is the only combinational output: dsmcl = ~(~asl & hit). All other outputs are registered.
- FSM states: IDLE, SETUP, STROBE, ACK, HOLD, RSTACK.
  - IDLE: on as_s=0, ds_s=0 and hit:
    - write to RST_ADDR -> RSTACK.
    - otherwise -> SETUP: wizcsl[ch]=0, dbenl=0, dbdir=rw_s. Channel and direction are latched.
  - SETUP: after SETUP_CYC cycles -> STROBE. wizrdl=0 on read, wizwrl=0 on write.
  - STROBE: after STROBE_CYC cycles -> ACK, dtackl=0.
  - ACK: strobe and cs held until ds_s=1 -> HOLD. dtackl=1 and the strobe deasserts on entry to HOLD.
  - HOLD: after HOLD_CYC cycles, cs=1 and dbenl=1 -> IDLE.
  - RSTACK: dtackl=0 and the wizrstl counter restarts at RESET_CYC (a retrigger extends the pulse). On ds_s=1 -> IDLE with dtackl=1. No cs or strobe is asserted.
- Latency: with the first rising edge sampling dsl=0 counted as edge 1:
  - cs falls at edge 3.
  - strobe falls at edge 3+SETUP_CYC.
  - dtackl falls at edge 3+SETUP_CYC+STROBE_CYC.
- Abort: if as_s rises in SETUP or STROBE, go to HOLD with no dtackl.
- No new cycle is accepted until IDLE is reached and as_s has been seen high.
- Counters are clog2(max parameter)+1 bits wide and load terminal-1. Values never wrap.

Optional Feature:
QE_BUS_TIMEOUT_EN
- Defined: a counter runs in ACK/RSTACK. After TIMEOUT_CYC cycles with ds_s still low, dtackl is released, the FSM goes to HOLD (or IDLE from RSTACK) and timeout_flag is set sticky until rst.
- Undefined: ACK/RSTACK wait indefinitely and timeout_flag is tied 0.

Decomposition:
- Package qe_bus_pkg holds:
  - the state enum;
  - DEC_BASE, RST_ADDR and timing defaults;
  - a clog2 helper function.
- Sub-module qe_sync2 is a 2-flop synchroniser with async active-high reset to a parameterised value of 1. It is instantiated for asl, dsl and rdwl.

Test Plan:
- Release rst -> wizrstl stays low exactly 20 cycles after rst falls; all other outputs at their reset values; busy=0.
- Write to 10'h320 -> wizcsl=2'b10; wizwrl low 3 cycles before dtackl falls at edge 7; dbdir=0; dsmcl=0 while asl=0.
- Read from 10'h324 -> wizcsl=2'b01, wizrdl=0, dbdir=1, dtackl=0 until dsl rises; cs released 1 cycle after the strobe.
- Access to 10'h048 -> dsmcl=1; no cs, strobe or dtackl; busy stays 0.
- Write to 10'h30c -> dtackl=0 with no cs or strobe; wizrstl low 20 cycles. A second write after 10 cycles extends the pulse to 20 cycles from the retrigger.
- rst asserted during STROBE -> all outputs reset immediately. With QE_BUS_TIMEOUT_EN, dsl held low 300 cycles -> timeout_flag=1 and dtackl released after 255 cycles.
